// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and the
// bit-counter width helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADD  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // One spare bit keeps WIDTH=1 legal ($clog2(1) is 0).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_b_if.sv
// One-bit full adder used as the bit slice of serial_adder. Purely
// combinational; it holds no state.
module full_adder_b_if (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop produce
// one sum bit per clock, LSB first, over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state
);

  // Handshake: start is a request sampled only in IDLE, together with a, b
  // and cin. There is no backpressure; done is a one-cycle pulse and
  // sum/cout stay valid until the next completion or reset.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_sum;
  logic             fa_cout;

  full_adder_b_if u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB-first stream ends up aligned.
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            count   <= '0;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= fa_cout;
          count  <= count + CW'(1);
          if (count == LAST) begin
            sum     <= res_next;
            cout    <= fa_cout;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == ST_ADD);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance driven from a vector
// table plus protocol/abort sequences, and a 1-bit instance swept exhaustively.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;
  } vec1_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic [1:0] state8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  logic [1:0] state1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vec8_t vecs8[8];
  vec1_t vecs1[8];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state(state8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state(state1)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit addition, scramble operands after acceptance, and
  // check latency, done pulse and held result.
  task automatic run8(input string name, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input logic [7:0] es, input logic ec);
    int cycles;
    @(negedge clk);
    start8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    cycles = 0;
    while (busy8 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, cycles, 8);
    chk({name, " done"}, done8, 1);
    chk({name, " sum"}, sum8, es);
    chk({name, " cout"}, cout8, ec);
    @(negedge clk);
    chk({name, " done_cleared"}, done8, 0);
    chk({name, " sum_held"}, {cout8, sum8}, {ec, es});
  endtask

  initial begin
    int t0, t1, guard, pulses;
    logic [7:0] pa, pb;

    vecs8[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs8[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs8[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs8[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs8[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held with start asserted: nothing may launch.
    rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset state", state8, 0);
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset sum", sum8, 8'h00);
    chk("reset cout", cout8, 0);
    chk("reset busy w1", busy1, 0);
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("post-reset idle", state8, 0);

    // Table-driven 8-bit vectors
    for (int i = 0; i < 8; i++)
      run8($sformatf("vec%0d", i), vecs8[i].a, vecs8[i].b, vecs8[i].cin,
           vecs8[i].sum, vecs8[i].cout);

    // Protocol: start held high, operands changing every cycle.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("proto first accept", busy8, 1);
    guard = 0;
    while (!done8 && guard < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      guard++;
      @(negedge clk);
    end
    chk("proto done seen", done8, 1);
    chk("proto sum", {cout8, sum8}, 9'h065);
    pa = 8'h10; pb = 8'h20;
    a8 = pa; b8 = pb; cin8 = 1'b0;
    guard = 0;
    while (!busy8 && guard < 40) begin
      guard++;
      @(negedge clk);
    end
    t1 = cyc;
    chk("proto reaccept spacing", t1 - t0, 10);
    start8 = 1'b0;
    guard = 0;
    while (!done8 && guard < 40) begin
      guard++;
      @(negedge clk);
    end
    chk("proto second sum", {cout8, sum8}, 9'h030);
    @(negedge clk);

    // Abort: reset during the 4th ADD cycle.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort still busy", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort state", state8, 0);
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort sum", sum8, 8'h00);
    chk("abort cout", cout8, 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    chk("abort no activity", pulses, 0);
    run8("after abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // WIDTH=1 instance: full truth table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = vecs1[i].a; b1 = vecs1[i].b; cin1 = vecs1[i].cin;
      @(negedge clk);
      start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      chk($sformatf("w1 tt%0d busy", i), {busy1, done1}, 2'b10);
      @(negedge clk);
      chk($sformatf("w1 tt%0d done", i), {busy1, done1}, 2'b01);
      chk($sformatf("w1 tt%0d result", i), {cout1, sum1}, {vecs1[i].cout, vecs1[i].sum});
      @(negedge clk);
      chk($sformatf("w1 tt%0d idle", i), state1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: latches two WIDTH-bit operands plus carry-in on a start pulse, then produces one sum bit per clock through a single full-adder cell and a carry flip-flop. It is the sequential stage built directly on top of the team's one-bit full adder (full_adder_b_if), which serves as its bit slice. It trades WIDTH cycles of latency for a one-cell datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in; sampled with start
- busy  output  1  high while in ADD
- done  output  1  one-cycle completion pulse; high in DONE
- sum  output  WIDTH  result; held stable between completions
- cout  output  1  final carry-out; held stable between completions

## Operation
- FSM states are IDLE, ADD, and DONE.
- IDLE, start=1:
  - load a->a_sh, b->b_sh, cin->carry, 0->bit count;
  - go to ADD.
- IDLE, start=0: stay in IDLE.
- ADD, each cycle:
  - the full adder takes a_sh[0], b_sh[0] and carry;
  - its sum bit shifts in at the MSB of res_sh while a_sh, b_sh and res_sh shift right by one;
  - carry <= full-adder cout;
  - count increments.
- ADD, final bit (count == WIDTH-1):
  - res_sh plus the new bit is copied into sum;
  - the new carry is copied into cout;
  - go to DONE.
- DONE: go to IDLE unconditionally.
- start is ignored in ADD and DONE. Back-to-back requests therefore need start in a cycle where the state is IDLE.
- Operand inputs are don't-care outside the start-sampling cycle. Changing them mid-operation has no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- The count register is $clog2(WIDTH)+1 bits wide. WIDTH=1 yields exactly one ADD cycle.
- Reset values, all forced at the first clk edge with rst=1:
  - state=IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - shift registers, carry and count all 0.
- Reset mid-operation aborts the addition. sum and cout return to 0, not to the previous result.
- rst has priority over start in the same cycle.

## Timing
- Start accepted at edge k (state IDLE, start=1).
- busy=1 for the WIDTH cycles following edge k, through edge k+WIDTH.
- sum and cout update at edge k+WIDTH. done=1 for exactly one cycle, from edge k+WIDTH to edge k+WIDTH+1.
- Earliest next accepted start is at edge k+WIDTH+2. Throughput is one addition per WIDTH+2 cycles.
- busy and done decode directly from the state register (Moore). No combinational path from inputs to outputs.
- sum and cout change only at the completion edge and at reset.

## Structure
- Shared package / header serial_adder_pkg:
  - state encodings: IDLE=2'b00, ADD=2'b01, DONE=2'b10;
  - count-width helper.
- One sub-module: full_adder_b_if, instantiated once as the bit slice. It has no state of its own, and all registers live in serial_adder.
- Unused state 2'b11 recovers to IDLE.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, sum=8'h00, cout=0, no operation launched.
- Basic (WIDTH=8): a=8'h3C, b=8'h5A, cin=0, one-cycle start -> busy=1 for 8 cycles, single done pulse, sum=8'h96, cout=0; sum then holds.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1;
  - then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Protocol:
  - hold start=1 continuously and change a and b every cycle during ADD -> the result equals the sum of the operands latched at acceptance;
  - the next accept occurs exactly WIDTH+2 cycles after the first.
- Abort: a=8'h12, b=8'h34, assert rst during the 4th ADD cycle -> next cycle state=IDLE, busy=0, done=0, sum=0, cout=0 with no done pulse; a fresh start then yields sum=8'h46.
- WIDTH=1 instance: sweep all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table, busy high for 1 cycle, done on the following cycle.
